// File: rtl/single_macc_pkg.sv
// Shared constants, FSM encoding and elaboration helpers for the single-MACC
// polyphase filters (interpolator and decimator).
package single_macc_pkg;

    localparam int DefDataWidth  = 18;
    localparam int DefCoeffWidth = 18;

    // Coefficients are Q1.(CoeffWidth-1); products are rescaled by this shift.
    localparam int CoeffFrac = DefCoeffWidth - 1;

    localparam logic [DefDataWidth-1:0] SatMax = 18'h1FFFF;
    localparam logic [DefDataWidth-1:0] SatMin = 18'h20000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/single_macc_interpolator_macc.sv
// Registered multiply, reload/accumulate and floor-shift-saturate stage shared
// by the single-MACC filters.
module macc_unit
    import single_macc_pkg::*;
#(
    parameter int DataWidth  = DefDataWidth,
    parameter int CoeffWidth = DefCoeffWidth,
    parameter int AccWidth   = DefDataWidth + DefCoeffWidth + 3,
    parameter int FracBits   = CoeffFrac
) (
    input  logic                  Clk_i,
    input  logic                  Rst_i,
    input  logic                  i_vld,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic [DataWidth-1:0]  i_sample,
    input  logic [CoeffWidth-1:0] i_coef,
    output logic [DataWidth-1:0]  o_data,
    output logic                  o_valid
);

    localparam int ProdWidth = DataWidth + CoeffWidth;
    localparam logic signed [AccWidth-1:0] AccHi = AccWidth'((64'sd1 <<< (DataWidth - 1)) - 64'sd1);
    localparam logic signed [AccWidth-1:0] AccLo = ~AccHi;

    logic signed [ProdWidth-1:0] w_prod;
    logic signed [ProdWidth-1:0] r_prod;
    logic                        r_prod_vld;
    logic                        r_prod_first;
    logic                        r_prod_last;
    logic signed [AccWidth-1:0]  r_acc;
    logic signed [AccWidth-1:0]  w_acc_next;
    logic signed [AccWidth-1:0]  w_shifted;
    logic [DataWidth-1:0]        w_sat;

    assign w_prod = $signed({{CoeffWidth{i_sample[DataWidth-1]}}, i_sample})
                  * $signed({{DataWidth{i_coef[CoeffWidth-1]}}, i_coef});

    // Tap 0 of a phase reloads so consecutive phases need no clearing bubble.
    always_comb begin
        w_acc_next = r_prod_first ? AccWidth'(r_prod) : r_acc + AccWidth'(r_prod);
        w_shifted  = w_acc_next >>> FracBits;
        if (w_shifted > AccHi) begin
            w_sat = AccHi[DataWidth-1:0];
        end else if (w_shifted < AccLo) begin
            w_sat = AccLo[DataWidth-1:0];
        end else begin
            w_sat = w_shifted[DataWidth-1:0];
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_prod       <= '0;
            r_prod_vld   <= 1'b0;
            r_prod_first <= 1'b0;
            r_prod_last  <= 1'b0;
            r_acc        <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
        end else begin
            r_prod       <= w_prod;
            r_prod_vld   <= i_vld;
            r_prod_first <= i_first;
            r_prod_last  <= i_last;
            o_valid      <= r_prod_vld & r_prod_last;
            if (r_prod_vld) begin
                r_acc <= w_acc_next;
            end
            if (r_prod_vld && r_prod_last) begin
                o_data <= w_sat;
            end
        end
    end

endmodule

// File: rtl/single_macc_interpolator.sv
// Polyphase interpolate-by-K FIR: each accepted sample is run through all K
// branches on one MACC, yielding K output strobes spaced TapsPerPhase cycles.
module single_macc_interpolator
    import single_macc_pkg::*;
#(
    parameter int InterpolationK = 2,
    parameter int TapsPerPhase   = 8,
    parameter int DataWidth      = 18,
    parameter int CoeffWidth     = 18,
    parameter int CoeffAddrWidth = 4
) (
    input  logic                      Clk_i,
    input  logic                      Rst_i,
    input  logic [CoeffAddrWidth-1:0] CoeffAddr_i,
    input  logic [CoeffWidth-1:0]     CoeffData_i,
    input  logic                      CoeffWr_i,
    input  logic [DataWidth-1:0]      Data_i,
    input  logic                      DataNd_i,
    output logic                      Ready_o,
    output logic [DataWidth-1:0]      Data_o,
    output logic                      DataValid_o,
    output logic                      DropErr_o
);

    localparam int NTaps    = InterpolationK * TapsPerPhase;
    localparam int TapW     = (clog2(TapsPerPhase) < 1) ? 1 : clog2(TapsPerPhase);
    localparam int PhW      = (clog2(InterpolationK) < 1) ? 1 : clog2(InterpolationK);
    localparam int AccWidth = DataWidth + CoeffWidth + clog2(TapsPerPhase);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [CoeffWidth-1:0] r_coef_ram [NTaps];
    logic [DataWidth-1:0]  r_dl [TapsPerPhase];
    logic [TapW-1:0]       r_wrptr;
    logic [TapW-1:0]       r_newest;
    logic [TapW-1:0]       r_tap;
    logic [PhW-1:0]        r_phase;
    logic [DataWidth-1:0]  r_rd_sample;
    logic [CoeffWidth-1:0] r_rd_coef;
    logic                  r_rd_vld;
    logic                  r_rd_first;
    logic                  r_rd_last;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_tap_last;
    logic                  w_last_issue;
    logic                  w_out_valid;
    int                    w_idx;
    logic [TapW-1:0]       w_rd_idx;
    logic [CoeffAddrWidth-1:0] w_coef_addr;

    assign Ready_o      = (r_state == IDLE);
    assign w_accept     = DataNd_i & Ready_o;
    assign w_issue      = (r_state == MAC);
    assign w_tap_last   = (r_tap == TapW'(TapsPerPhase - 1));
    assign w_last_issue = w_issue & w_tap_last & (r_phase == PhW'(InterpolationK - 1));
    assign DataValid_o  = w_out_valid;

    // Tap t of phase p pairs x[n-t] with c[p + K*t].
    always_comb begin
        w_idx       = (int'(r_newest) - int'(r_tap) + TapsPerPhase) % TapsPerPhase;
        w_rd_idx    = TapW'(w_idx);
        w_coef_addr = CoeffAddrWidth'(int'(r_phase) + InterpolationK * int'(r_tap));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = MAC;
            MAC:     if (w_last_issue) w_state_nxt = DRAIN;
            DRAIN:   if (w_out_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Coefficient RAM is deliberately outside reset and writable while busy.
    always_ff @(posedge Clk_i) begin
        if (CoeffWr_i) begin
            r_coef_ram[CoeffAddr_i] <= CoeffData_i;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_state     <= IDLE;
            r_wrptr     <= '0;
            r_newest    <= '0;
            r_tap       <= '0;
            r_phase     <= '0;
            r_rd_sample <= '0;
            r_rd_coef   <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_first  <= 1'b0;
            r_rd_last   <= 1'b0;
            DropErr_o   <= 1'b0;
            for (int i = 0; i < TapsPerPhase; i++) begin
                r_dl[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            DropErr_o   <= DataNd_i & ~Ready_o;
            r_rd_sample <= r_dl[w_rd_idx];
            r_rd_coef   <= r_coef_ram[w_coef_addr];
            r_rd_vld    <= w_issue;
            r_rd_first  <= w_issue & (r_tap == '0);
            r_rd_last   <= w_issue & w_tap_last;
            if (w_accept) begin
                r_dl[r_wrptr] <= Data_i;
                r_newest      <= r_wrptr;
                r_wrptr       <= (r_wrptr == TapW'(TapsPerPhase - 1)) ? '0 : r_wrptr + 1'b1;
                r_tap         <= '0;
                r_phase       <= '0;
            end else if (w_issue) begin
                if (w_tap_last) begin
                    r_tap   <= '0;
                    r_phase <= r_phase + 1'b1;
                end else begin
                    r_tap <= r_tap + 1'b1;
                end
            end
        end
    end

    macc_unit #(
        .DataWidth  (DataWidth),
        .CoeffWidth (CoeffWidth),
        .AccWidth   (AccWidth),
        .FracBits   (CoeffWidth - 1)
    ) u_macc (
        .Clk_i    (Clk_i),
        .Rst_i    (Rst_i),
        .i_vld    (r_rd_vld),
        .i_first  (r_rd_first),
        .i_last   (r_rd_last),
        .i_sample (r_rd_sample),
        .i_coef   (r_rd_coef),
        .o_data   (Data_o),
        .o_valid  (w_out_valid)
    );

endmodule

// File: doc/single_macc_interpolator.md
Name: single_macc_interpolator

Overview:
- Polyphase FIR interpolator by InterpolationK built around one multiply-accumulate unit; transmit-side counterpart of the single-MACC decimator.
- Each accepted input sample produces InterpolationK filtered output samples, one per polyphase branch.
- Coefficient RAM is written on the same clock as the datapath and holds InterpolationK*TapsPerPhase taps.
- Sits between a low-rate sample source and a high-rate consumer (DAC / upconverter path).

Parameters:
- InterpolationK, 2, upsampling factor (2..8).
- TapsPerPhase, 8, taps per polyphase branch; total taps N = InterpolationK*TapsPerPhase (power of 2).
- DataWidth, 18, signed input/output width.
- CoeffWidth, 18, signed Q1.17 coefficient width.
- CoeffAddrWidth, 4, clog2(N).

Ports:
- Clk_i  in  1  single clock for all logic.
- Rst_i  in  1  synchronous, active-high reset.
- CoeffAddr_i  in  CoeffAddrWidth  coefficient write address.
- CoeffData_i  in  CoeffWidth  coefficient value, Q1.17.
- CoeffWr_i  in  1  coefficient write strobe.
- Data_i  in  DataWidth  input sample.
- DataNd_i  in  1  new-data strobe.
- Ready_o  out  1  high when DataNd_i will be accepted.
- Data_o  out  DataWidth  output sample.
- DataValid_o  out  1  one-cycle output strobe.
- DropErr_o  out  1  one-cycle pulse when DataNd_i arrives while not ready.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - Ready_o=1, Data_o=0, DataValid_o=0, DropErr_o=0.
  - Delay line (TapsPerPhase x DataWidth) cleared to 0; write pointer and state set to IDLE.
  - Coefficient RAM is not cleared.
- Coefficient writes:
  - Taken on any cycle with CoeffWr_i=1, including while busy.
  - A read of the same address in the same cycle returns the old value.
- Accept rule:
  - Sample accepted at cycle 0 when DataNd_i=1 and Ready_o=1.
  - Sample is written at the circular write pointer, which then advances with wrap at TapsPerPhase-1.
  - Ready_o drops at cycle 1.
- Not-ready input: DataNd_i while Ready_o=0 drops the sample, pulses DropErr_o on the next cycle, and leaves state untouched.
- FSM, IDLE -> MAC -> DRAIN -> IDLE:
  - MAC: for phase p = 0..K-1 and tap t = 0..T-1, issue one cycle per tap.
    - Coefficient address: c[p + K*t].
    - Sample: x[n-t], read from the delay line at (wrptr_newest - t) mod T.
    - Total K*T issue cycles.
  - Pipeline: 1 cycle coefficient/sample read, then 1 cycle registered product, then accumulate.
    - The accumulator reloads, not adds, on tap 0 of each phase, so phases run back to back.
  - DRAIN: flush the pipeline after the last issue.
    - Ready_o returns high the cycle after the final DataValid_o.
- Latency:
  - Output for phase p has DataValid_o at cycle L + p*T, where L = T+3 (11 for T=8).
  - Minimum input spacing is K*T+4 cycles (20 at defaults).
- Arithmetic:
  - Product is DataWidth+CoeffWidth signed (36 bits).
  - Accumulator is 36 + clog2(T) bits; no internal overflow.
  - Data_o = saturate(acc >>> (CoeffWidth-1)) to DataWidth signed, truncating (floor).
  - Saturation limits are 0x1FFFF and 0x20000.
- Data_o holds its last value between strobes.
- Reset mid-operation: the output sequence is aborted (no further DataValid_o), Ready_o=1 on the next cycle, and the delay line is zeroed.

Decomposition:
- Package single_macc_pkg:
  - Q-format constant (CoeffFrac = CoeffWidth-1).
  - Saturation limit constants.
  - FSM state enum {IDLE, MAC, DRAIN}.
  - clog2 function.
- Natural sub-module: macc_unit (registered multiply, reload/accumulate, shift and saturate). The same unit can be shared with the decimator.

Test Plan:
1. Impulse response:
   - Stimulus: c[n]=(n+1)*1024; input 0x10000 then zeros, spaced 32 cycles.
   - Required: outputs 512, 1024, 1536, ..., 8192 in order (c[n]/2), then all zeros.
2. DC gain:
   - Stimulus: all c = 4096; input 0x10000 repeated.
   - Required: after 8 samples, every output = 16384.
3. Saturation:
   - All c = 0x1FFFF with input 0x1FFFF repeated -> steady output 0x1FFFF.
   - Input 0x20000 repeated -> steady output 0x20000.
4. Latency and handshake (T=8, K=2):
   - DataValid_o at cycles 11 and 19 after acceptance.
   - Ready_o low for cycles 1..19, high at cycle 20.
   - A second DataNd_i at cycle 20 is accepted.
5. Drop:
   - Stimulus: DataNd_i at cycle 5 after acceptance.
   - Required: DropErr_o pulse at cycle 6; output values and timing are identical to the no-drop run.
6. Reset mid-MAC:
   - Stimulus: Rst_i at cycle 7 after acceptance.
   - Required: no DataValid_o, Ready_o=1 at the next cycle, and a following impulse reproduces test 1 exactly with coefficients retained.
